// File: rtl/setcond_stage.sv
// setcond_stage: execute-stage set-condition unit.
// Evaluates SEQ / SLT / SLE / SCO on two operands, registers a single
// condition bit tagged with its destination register, and hands it to the
// zero-extension stage through a two-entry valid/ready pipeline.
//
// Handshake semantics (both ports): a transfer happens on a rising clock
// edge where valid && ready. A producer that raises valid keeps it high with
// stable data until that transfer; valid never waits on ready, and ready is
// computed only from pipeline state (never from the matching valid).
module setcond_stage #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [REGW-1:0]  in_dest,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cond,
  output logic [REGW-1:0]  out_dest
);

  typedef enum logic [1:0] {
    OP_SEQ = 2'b00,
    OP_SLT = 2'b01,
    OP_SLE = 2'b10,
    OP_SCO = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Stage 1 holding registers
  logic             v1;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [REGW-1:0]  s1_dest;

  // Stage 2 registers
  logic             v2;
  logic             s2_cond;
  logic [REGW-1:0]  s2_dest;

  // Pipeline control
  logic s2_free;
  logic s1_adv;
  logic s1_free;
  logic in_xfer;
  logic out_xfer;

  // Condition datapath
  logic a_msb;
  logic b_msb;
  logic diff_msb;
  logic eq;
  logic lt;
  logic carry;
  logic cond_next;

  // Advance rules: S2 empties on consumer accept, S1 empties into S2.
  always_comb begin
    s2_free  = !v2 || out_ready;
    s1_adv   = v1 && s2_free;
    s1_free  = !v1 || s2_free;
    in_xfer  = in_valid && s1_free;
    out_xfer = v2 && out_ready;
  end

  assign in_ready  = s1_free;
  assign out_valid = v2;
  assign cond      = s2_cond;
  assign out_dest  = s2_dest;

  // Signed less-than: on differing signs the negative operand is smaller,
  // which sidesteps the overflow a plain subtraction would hit; otherwise
  // the sign of a - b (computed as a + ~b + 1) decides.
  always_comb begin
    a_msb    = s1_a[WIDTH-1];
    b_msb    = s1_b[WIDTH-1];
    diff_msb = 1'((s1_a + ~s1_b + ONE) >> (WIDTH - 1));
    eq       = (s1_a == s1_b);
    lt       = (a_msb != b_msb) ? a_msb : diff_msb;
    carry    = 1'(({1'b0, s1_a} + {1'b0, s1_b}) >> WIDTH);
  end

  // Select the condition for the opcode held in stage 1.
  always_comb begin
    cond_next = 1'b0;
    unique case (s1_op)
      OP_SEQ:  cond_next = eq;
      OP_SLT:  cond_next = lt;
      OP_SLE:  cond_next = lt || eq;
      OP_SCO:  cond_next = carry;
      default: cond_next = 1'b0;
    endcase
  end

  // Stage 1: capture an accepted bundle; flush squashes it and any new accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1      <= 1'b0;
      s1_op   <= OP_SEQ;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_dest <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (in_xfer) begin
      v1      <= 1'b1;
      s1_op   <= op_e'(op);
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_dest <= in_dest;
    end else if (s1_adv) begin
      v1 <= 1'b0;
    end
  end

  // Stage 2: register the condition bit; hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2      <= 1'b0;
      s2_cond <= 1'b0;
      s2_dest <= '0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (s1_adv) begin
      v2      <= 1'b1;
      s2_cond <= cond_next;
      s2_dest <= s1_dest;
    end else if (out_xfer) begin
      v2 <= 1'b0;
    end
  end

endmodule
